uar_rx_gen2: RTL and testbench

//  Parametrised asynchronous serial receiver; successor to the fixed 8-bit, x8-oversampled receiver.

---
 rtl/uar_pkg.sv | 26 ++
 rtl/uar_sampler.sv | 59 +++++
 rtl/uar_rx_gen2.sv | 141 ++++++++++++++
 tb/tb_uar_rx_gen2.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uar_pkg.sv
// Shared types and helpers for the uar_rx_gen2 serial receiver.
package uar_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uar_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uar_sampler.sv
// Line front end: 2-flop synchroniser, oversample tick counter,
// 3-sample majority vote around the bit centre and start-edge detect.
module uar_sampler
  import uar_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  input  logic restart_i,
  output logic edge_o,
  output logic bit_val_o,
  output logic bit_strobe_o,
  output logic bit_end_o
);

  localparam int TW  = clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;

  logic          sync1_q;
  logic          rx_s_q;
  logic          rx_prev_q;
  logic          samp_a_q;
  logic          samp_b_q;
  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;

  // The detect cycle counts as tick 0, so the counter resumes at 1.
  always_comb begin
    tick_d = tick_q + TW'(1);
    if (restart_i)                          tick_d = TW'(1);
    else if (tick_q == TW'(OVERSAMPLE - 1)) tick_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      samp_a_q  <= 1'b1;
      samp_b_q  <= 1'b1;
      tick_q    <= '0;
    end else begin
      sync1_q   <= din_i;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      tick_q    <= tick_d;
      if (tick_q == TW'(MID - 1)) samp_a_q <= rx_s_q;
      if (tick_q == TW'(MID))     samp_b_q <= rx_s_q;
    end
  end

  assign edge_o       = ~rx_s_q & rx_prev_q;
  assign bit_val_o    = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
  assign bit_strobe_o = (tick_q == TW'(MID + 1));
  assign bit_end_o    = (tick_q == TW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uar_rx_gen2.sv
// Parametrised async serial receiver: frame FSM, parity/framing checks
// and a held-output register with ack handshake and sticky overrun.
module uar_rx_gen2
  import uar_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 gl_reset,
  input  logic                 dIn,
  input  logic                 dAck,
  output logic [DATA_BITS-1:0] dOut,
  output logic                 dReady,
  output logic                 dError,
  output logic                 dParErr,
  output logic                 dOverrun
);

  localparam int BIW = clog2(DATA_BITS + 1);

  uar_state_e           state_q;
  logic [BIW-1:0]       bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 frm_err_q;

  logic [DATA_BITS-1:0] dout_q;
  logic                 ready_q;
  logic                 error_q;
  logic                 parerr_q;
  logic                 overrun_q;

  logic edge_det;
  logic bit_val;
  logic bit_strobe;
  logic bit_end;
  logic restart;
  logic done;
  logic frm_now;
  logic par_exp;

  uar_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk_i       (clk),
    .rst_i       (gl_reset),
    .din_i       (dIn),
    .restart_i   (restart),
    .edge_o      (edge_det),
    .bit_val_o   (bit_val),
    .bit_strobe_o(bit_strobe),
    .bit_end_o   (bit_end)
  );

  assign restart = (state_q == IDLE) && edge_det;
  assign done    = (state_q == STOP) && bit_strobe && (bit_idx_q == BIW'(STOP_BITS - 1));
  assign frm_now = frm_err_q | ~bit_val;
  assign par_exp = (^shift_q) ^ (PARITY_MODE == PAR_ODD);

  always_ff @(posedge clk or posedge gl_reset) begin
    if (gl_reset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_q   <= START;
            bit_idx_q <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end
        START: begin
          if (bit_strobe && bit_val) state_q <= IDLE;
          else if (bit_end)          state_q <= DATA;
        end
        DATA: begin
          if (bit_strobe) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx_q == BIW'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_idx_q <= bit_idx_q + BIW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_strobe) par_err_q <= (bit_val != par_exp);
          if (bit_end)    state_q   <= STOP;
        end
        STOP: begin
          // Leaving at the last stop decision keeps the next start edge catchable.
          if (bit_strobe) begin
            frm_err_q <= frm_now;
            if (done) state_q <= IDLE;
          end
          if (bit_end) bit_idx_q <= bit_idx_q + BIW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge gl_reset) begin
    if (gl_reset) begin
      dout_q    <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      parerr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else if (done) begin
      if (!ready_q || dAck) begin
        dout_q   <= shift_q;
        ready_q  <= 1'b1;
        error_q  <= frm_now;
        parerr_q <= par_err_q;
        if (dAck) overrun_q <= 1'b0;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (dAck && ready_q) begin
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign dOut     = dout_q;
  assign dReady   = ready_q;
  assign dError   = error_q;
  assign dParErr  = parerr_q;
  assign dOverrun = overrun_q;

endmodule

// File: tb/tb_uar_rx_gen2.sv
// Directed bench for uar_rx_gen2: one 8N1 instance and one 8E1 instance.
module tb_uar_rx_gen2;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       gl_reset = 1'b1;
  logic       din_a = 1'b1;
  logic       din_b = 1'b1;
  logic       ack_a = 1'b0;
  logic       ack_b = 1'b0;
  logic [7:0] dout_a, dout_b;
  logic       rdy_a, err_a, perr_a, ovr_a;
  logic       rdy_b, err_b, perr_b, ovr_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int c0 = 0;
  logic rdy_prev = 1'b0;

  always #5 clk = ~clk;

  uar_rx_gen2 #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .gl_reset(gl_reset), .dIn(din_a), .dAck(ack_a),
    .dOut(dout_a), .dReady(rdy_a), .dError(err_a), .dParErr(perr_a), .dOverrun(ovr_a)
  );

  uar_rx_gen2 #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .gl_reset(gl_reset), .dIn(din_b), .dAck(ack_b),
    .dOut(dout_b), .dReady(rdy_b), .dError(err_b), .dParErr(perr_b), .dOverrun(ovr_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy_a && !rdy_prev) rise_cyc = cyc;
    rdy_prev = rdy_a;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) din_b = v;
    else     din_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] data, input bit use_par,
                      input bit par_bit, input bit stop_bit);
    @(posedge clk); #1 set_line(sel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (OS) @(posedge clk);
      #1 set_line(sel, data[i]);
    end
    if (use_par) begin
      repeat (OS) @(posedge clk);
      #1 set_line(sel, par_bit);
    end
    repeat (OS) @(posedge clk);
    #1 set_line(sel, stop_bit);
    repeat (OS) @(posedge clk);
    #1 set_line(sel, 1'b1);
    repeat (6) @(posedge clk);
  endtask

  task automatic ack(input bit sel);
    @(posedge clk); #1;
    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
    @(posedge clk); #1;
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 16'(dout_a), 16'h00);
    check("rst_ready", 16'(rdy_a), 16'h0);
    check("rst_err", 16'(err_a), 16'h0);
    check("rst_ovr", 16'(ovr_a), 16'h0);
    gl_reset = 1'b0;
    repeat (5) @(posedge clk);

    // 1: 8N1 0xA5, readiness latency from the falling start edge
    rise_cyc = -1;
    fork
      send(0, 8'hA5, 0, 0, 1);
      begin @(posedge clk); #1 c0 = cyc; end
    join
    check("t1_dout", 16'(dout_a), 16'hA5);
    check("t1_ready", 16'(rdy_a), 16'h1);
    check("t1_err", 16'(err_a), 16'h0);
    check("t1_perr", 16'(perr_a), 16'h0);
    check("t1_latency", 16'(rise_cyc - c0), 16'd80);
    ack(0);
    check("t1_ack_ready", 16'(rdy_a), 16'h0);

    // 2: even parity, wrong then right parity bit
    send(1, 8'h3C, 1, 1, 1);
    check("t2_dout", 16'(dout_b), 16'h3C);
    check("t2_perr", 16'(perr_b), 16'h1);
    check("t2_ready", 16'(rdy_b), 16'h1);
    check("t2_err", 16'(err_b), 16'h0);
    ack(1);
    send(1, 8'h3D, 1, 1, 1);
    check("t2b_dout", 16'(dout_b), 16'h3D);
    check("t2b_perr", 16'(perr_b), 16'h0);
    ack(1);

    // 3: framing error, then a clean frame
    send(0, 8'h55, 0, 0, 0);
    check("t3_err", 16'(err_a), 16'h1);
    check("t3_dout", 16'(dout_a), 16'h55);
    check("t3_ready", 16'(rdy_a), 16'h1);
    ack(0);
    check("t3_ack_ready", 16'(rdy_a), 16'h0);
    send(0, 8'h0F, 0, 0, 1);
    ack(0);
    check("t3b_err", 16'(err_a), 16'h0);
    check("t3b_dout", 16'(dout_a), 16'h0F);
    check("t3b_ready", 16'(rdy_a), 16'h0);

    // 4: 3-cycle glitch is a false start
    @(posedge clk); #1 din_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 din_a = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("t4_no_ready", 16'(rdy_a), 16'h0);
    send(0, 8'h3A, 0, 0, 1);
    check("t4_dout", 16'(dout_a), 16'h3A);
    check("t4_err", 16'(err_a), 16'h0);
    ack(0);

    // 5: overrun, ack clears it; completion and ack in the same cycle
    send(0, 8'h11, 0, 0, 1);
    send(0, 8'h22, 0, 0, 1);
    check("t5_dout", 16'(dout_a), 16'h11);
    check("t5_ovr", 16'(ovr_a), 16'h1);
    check("t5_ready", 16'(rdy_a), 16'h1);
    ack(0);
    check("t5_ack_ready", 16'(rdy_a), 16'h0);
    check("t5_ack_ovr", 16'(ovr_a), 16'h0);
    send(0, 8'h44, 0, 0, 1);
    check("t5b_dout", 16'(dout_a), 16'h44);
    fork
      send(0, 8'h33, 0, 0, 1);
      begin
        repeat (80) @(posedge clk);
        #1 ack_a = 1'b1;
        @(posedge clk);
        #1 ack_a = 1'b0;
      end
    join
    check("t5c_dout", 16'(dout_a), 16'h33);
    check("t5c_ready", 16'(rdy_a), 16'h1);
    check("t5c_ovr", 16'(ovr_a), 16'h0);

    // 6: reset mid-frame, then a clean frame
    send(0, 8'h66, 0, 0, 1);
    check("t6_pre_ovr", 16'(ovr_a), 16'h1);
    @(posedge clk); #1 din_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (OS) @(posedge clk);
      #1 din_a = (i % 2 == 0);
    end
    repeat (4) @(posedge clk);
    #1 gl_reset = 1'b1;
    #1;
    check("t6_dout", 16'(dout_a), 16'h00);
    check("t6_ready", 16'(rdy_a), 16'h0);
    check("t6_ovr", 16'(ovr_a), 16'h0);
    check("t6_err", 16'(err_a), 16'h0);
    din_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 gl_reset = 1'b0;
    repeat (10) @(posedge clk);
    send(0, 8'h81, 0, 0, 1);
    check("t6b_dout", 16'(dout_a), 16'h81);
    check("t6b_ready", 16'(rdy_a), 16'h1);
    check("t6b_err", 16'(err_a), 16'h0);
    check("t6b_ovr", 16'(ovr_a), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
